// File: rtl/logic_op_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one 2-input logic evaluator between NUM_REQ
// requesters. Each grant latches the winner's operands, holds the evaluator
// for EXEC_CYCLES cycles and then returns the result with a one-hot done pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | evaluator free, arbitrating among pending requests
// ST_BUSY | evaluator held for the granted requester, counting down
// ST_RESP | done pulse visible, evaluator released on the next edge
module logic_op_scheduler #(
   parameter  int NUM_REQ     = 4,
   parameter  int EXEC_CYCLES = 2,
   localparam int PTR_W       = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     a,
   input  logic [NUM_REQ-1:0]     b,
   input  logic [2*NUM_REQ-1:0]   op,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     done,
   output logic                   result,
   output logic                   busy
);

   localparam int SUM_W = PTR_W + 1;
   localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               result_q, result_d;
   logic               busy_q, busy_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   win_q, win_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               a_q, a_d;
   logic               b_q, b_d;
   logic [1:0]         op_q, op_d;

   logic [SUM_W-1:0]   scan_idx;
   logic [PTR_W-1:0]   win_idx;
   logic               win_found;
   logic [PTR_W-1:0]   ptr_after;
   logic               eval_res;

   // Winner search: first set req bit starting at the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      scan_idx  = '0;
      win_idx   = '0;
      win_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = {1'b0, ptr_q} + SUM_W'(i);
         if (scan_idx >= SUM_W'(NUM_REQ)) begin
            scan_idx = scan_idx - SUM_W'(NUM_REQ);
         end
         if (!win_found && req[scan_idx[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[PTR_W-1:0];
         end
      end
   end

   // Pointer moves one past the served requester, wrapping after the last one.
   always_comb begin
      ptr_after = '0;
      if (win_q != PTR_W'(NUM_REQ - 1)) begin
         ptr_after = win_q + PTR_W'(1);
      end
   end

   // Shared evaluator on the latched operands.
   always_comb begin
      eval_res = 1'b0;
      case (op_q)
         2'b00:   eval_res = a_q | b_q;
         2'b01:   eval_res = a_q & b_q;
         2'b10:   eval_res = a_q ^ b_q;
         default: eval_res = ~(a_q | b_q);
      endcase
   end

   // Next-state and registered outputs of the IDLE/BUSY/RESP sequence.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      done_d   = done_q;
      result_d = result_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               gnt_d   = ONE_HOT0 << win_idx;
               win_d   = win_idx;
               a_d     = a[win_idx];
               b_d     = b[win_idx];
               op_d    = op[{win_idx, 1'b0} +: 2];
               cnt_d   = CNT_W'(EXEC_CYCLES - 1);
               busy_d  = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               result_d = eval_res;
               done_d   = gnt_q;
               gnt_d    = '0;
               ptr_d    = ptr_after;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            done_d  = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            done_d  = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= 1'b0;
         busy_q   <= 1'b0;
         ptr_q    <= '0;
         win_q    <= '0;
         cnt_q    <= '0;
         a_q      <= 1'b0;
         b_q      <= 1'b0;
         op_q     <= 2'b00;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
      end
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign result = result_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
`timescale 1ns/1ps
// Bench for logic_op_scheduler: directed stimulus pushes expected
// (requester, result) pairs; a monitor pops them on every done pulse.
module tb_logic_op_scheduler;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] a   = '0;
   logic [N-1:0] b   = '0;
   logic [2*N-1:0] op = '0;
   logic [N-1:0] gnt;
   logic [N-1:0] done;
   logic         result;
   logic         busy;

   typedef struct {
      int   idx;
      logic res;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   logic [3:0] tt [4];

   logic_op_scheduler #(.NUM_REQ(N), .EXEC_CYCLES(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .a      (a),
      .b      (b),
      .op     (op),
      .gnt    (gnt),
      .done   (done),
      .result (result),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic push(input int idx, input logic res);
      exp_t e;
      e.idx = idx;
      e.res = res;
      exp_q.push_back(e);
   endtask

   // Monitor: invariants every cycle, scoreboard compare on each done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         check("invariant", {31'd0, $onehot0(gnt) & $onehot0(done) & ~(|gnt & |done)}, 32'd1);
         if (done != '0) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done got=%b want=none", done);
            end else begin
               e = exp_q.pop_front();
               check("done_id", {28'd0, done}, 32'd1 << e.idx);
               check("result", {31'd0, result}, {31'd0, e.res});
            end
         end
      end
   end

   // Wait for n done pulses, dropping each served requester's req on the RESP edge.
   task automatic serve(input int n);
      logic [N-1:0] d;
      int k;
      for (int j = 0; j < n; j++) begin
         k = 0;
         while (done == '0 && k < 50) begin
            @(negedge clk);
            k++;
         end
         if (done == '0) begin
            check("serve_timeout", 32'd0, 32'd1);
            return;
         end
         d = done;
         @(posedge clk);
         #1;
         req = req & ~d;
      end
   endtask

   task automatic wait_gnt(output logic ok);
      int k;
      k = 0;
      while (gnt == '0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      ok = (gnt != '0);
      if (!ok) check("gnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_op(input int idx, input logic av, input logic bv, input logic [1:0] opc,
                        input logic want);
      a[idx] = av;
      b[idx] = bv;
      op[2*idx +: 2] = opc;
      req[idx] = 1'b1;
      push(idx, want);
      serve(1);
   endtask

   initial begin
      logic ok;
      int   last_cyc;
      tt[0] = 4'b1110;
      tt[1] = 4'b1000;
      tt[2] = 4'b0110;
      tt[3] = 4'b0001;

      // reset values
      repeat (2) @(negedge clk);
      check("rst_gnt", {28'd0, gnt}, 32'd0);
      check("rst_done", {28'd0, done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", {31'd0, result}, 32'd0);
      rst = 1'b0;

      // 1: single OR request, latency
      @(posedge clk); #1;
      a = 4'b0000; b = 4'b0001; op = '0; req = 4'b0001;
      push(0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("t1_gnt", {28'd0, gnt}, 32'h1);
      check("t1_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("t1_no_done_yet", {28'd0, done}, 32'h0);
      @(negedge clk);
      check("t1_done", {28'd0, done}, 32'h1);
      check("t1_gnt_off", {28'd0, gnt}, 32'h0);
      @(posedge clk); #1;
      req = '0;
      @(negedge clk);
      check("t1_busy_off", {31'd0, busy}, 32'd0);

      // 2: truth table for requester 2
      for (int o = 0; o < 4; o++) begin
         for (int ab = 0; ab < 4; ab++) begin
            do_op(2, ab[1], ab[0], o[1:0], tt[o][ab]);
         end
      end

      // 3: all requesting, rotation and grant spacing
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      a = 4'b1111; b = 4'b1100; op = 8'b10101010;
      for (int g = 0; g < 8; g++) push(g % 4, (g % 4) < 2);
      req = 4'b1111;
      last_cyc = 0;
      for (int g = 0; g < 8; g++) begin
         wait_gnt(ok);
         if (ok) begin
            check("t3_order", {28'd0, gnt}, 32'd1 << (g % 4));
            if (g > 0) check("t3_gap", cyc - last_cyc, 32'd4);
            last_cyc = cyc;
            while (gnt != '0) @(negedge clk);
         end
      end
      @(posedge clk); #1;
      req = '0;

      // 4: pointer at 3, then wrap
      do_op(2, 1'b0, 1'b0, 2'b11, 1'b1);
      a = 4'b1001; b = 4'b1000; op = 8'b01000001;
      push(3, 1'b1);
      push(0, 1'b0);
      req = 4'b1001;
      serve(2);
      a = 4'b0001; b = 4'b0000; op = 8'b00000000;
      push(1, 1'b0);
      push(0, 1'b1);
      req = 4'b0011;
      serve(2);

      // 5: operands and req change during BUSY
      a = 4'b0100; b = 4'b0100; op = 8'b00010000;
      push(2, 1'b1);
      req = 4'b0100;
      wait_gnt(ok);
      a = 4'b0000; b = 4'b0000; op = 8'b00000000; req = 4'b0000;
      serve(1);

      // 6: reset during BUSY
      a = 4'b0100; b = 4'b0100; op = 8'b00000000;
      req = 4'b0100;
      wait_gnt(ok);
      rst = 1'b1;
      #1;
      check("t6_gnt", {28'd0, gnt}, 32'd0);
      check("t6_done", {28'd0, done}, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_result", {31'd0, result}, 32'd0);
      req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      a = 4'b0001; b = 4'b1001; op = 8'b10000010;
      push(0, 1'b0);
      push(3, 1'b1);
      req = 4'b1001;
      serve(2);

      repeat (4) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
